pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: max consecutive data-memory wait cycles before timeout error.
REQ-002 SHALL have parameter CNT_W, default 32: width of performance counters.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port hz_stall  input  1  load-use stall request from hazard unit.
REQ-006 SHALL have port hz_flush  input  1  branch-taken/jump flush request from hazard unit.
REQ-007 SHALL have port imem_ready  input  1  instruction fetch data valid this cycle.
REQ-008 SHALL have port dmem_req  input  1  MEM-stage load/store present.
REQ-009 SHALL have port dmem_ready  input  1  data memory completes access this cycle.
REQ-010 SHALL have port halt_req  input  1  ecall/ebreak reached WB.
REQ-011 SHALL have ports pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we  output  1 each  register write enables.
REQ-012 SHALL have ports if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  output  1 each  insert bubble.
REQ-013 SHALL have ports halted  output  1, timeout_err  output  1, state  output  2.
REQ-014 SHALL have ports stall_cycles, flush_count  output  CNT_W each  performance counters.

Function
REQ-015 SHALL implement FSM states INIT, RUN, MEM_WAIT, HALT.
REQ-016 SHALL leave INIT for RUN after exactly one cycle; in INIT all flushes SHALL be 1 and all write enables 0.
REQ-017 In RUN, with dmem_req=1 and dmem_ready=0, SHALL enter MEM_WAIT; all write enables 0 that cycle.
REQ-018 In MEM_WAIT, all write enables SHALL be 0 and mem_wb_flush SHALL be 1 until dmem_ready=1; on dmem_ready=1 pipeline SHALL advance that same cycle and return to RUN.
REQ-019 Wait counter SHALL clear on MEM_WAIT entry and increment each MEM_WAIT cycle; reaching WAIT_MAX SHALL set timeout_err (sticky until reset) and go to HALT.
REQ-020 In an advancing RUN cycle, hz_flush=1 SHALL assert if_id_flush, id_ex_flush, ex_mem_flush with all enables 1.
REQ-021 hz_flush and hz_stall together SHALL resolve as flush; stall ignored.
REQ-022 hz_stall alone SHALL give pc_we=0, if_id_we=0, id_ex_flush=1, others enabled.
REQ-023 imem_ready=0 in RUN with no flush SHALL give pc_we=0, if_id_flush=1, back stages enabled; combined with hz_stall, stall rule governs IF/ID (if_id_we=0, no if_id_flush).
REQ-024 hz_flush asserted during MEM_WAIT SHALL be acted on only in the cycle the pipeline advances.
REQ-025 halt_req=1 in an advancing cycle SHALL enter HALT; HALT SHALL hold all enables 0, halted=1, until reset.
REQ-026 Outputs other than state/halted/timeout_err/counters SHALL be combinational from state and inputs (zero latency).
REQ-027 state SHALL encode INIT=0, RUN=1, MEM_WAIT=2, HALT=3.

Reset
REQ-028 reset_n=0 at a rising edge SHALL force INIT, clear wait counter, timeout_err, halted, counters, regardless of current state including MEM_WAIT.
REQ-029 While reset_n=0, all write enables SHALL be 0 and all flushes 1.

Configuration
REQ-030 With PIPE_PERF_EN defined, stall_cycles SHALL count cycles where pc_we=0 in RUN or MEM_WAIT, flush_count SHALL count applied hz_flush events, both saturating at all-ones.
REQ-031 Without PIPE_PERF_EN, stall_cycles and flush_count SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-032 State enum, state encodings and default CNT_W SHALL live in package pipe_ctrl_pkg.
REQ-033 Counters SHALL be one sub-module pipe_perf_cnt, instantiated only under PIPE_PERF_EN.

Verification
REQ-034 Reset release -> 1 cycle INIT (all flush=1), then RUN with all we=1 and state=1.
REQ-035 hz_stall=1 one cycle in RUN -> pc_we=0, if_id_we=0, id_ex_flush=1 that cycle only.
REQ-036 hz_stall=1 and hz_flush=1 same cycle -> if_id/id_ex/ex_mem_flush=1, pc_we=1, flush_count+1.
REQ-037 dmem_req=1, dmem_ready low 3 cycles -> state=2 for 3 cycles, all we=0, stall_cycles+=4; ready then all we=1.
REQ-038 dmem_ready held low 15 cycles with WAIT_MAX=15 -> timeout_err=1, state=3, halted=1.
REQ-039 reset_n=0 during MEM_WAIT -> next cycle state=0, counters 0, timeout_err=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and counter defaults.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  localparam int CNT_W_DEFAULT = 32;

  // Stall cycles are only meaningful while the pipeline is live.
  function automatic logic is_active(input state_t s);
    return (s == ST_RUN) || (s == ST_MEM_WAIT);
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating performance counters for stall cycles and applied flushes.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  logic [1:0] inc;

  assign inc = {flush_inc, stall_inc};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else if (inc[gi] && (cnt_reg != '1)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  assign stall_cycles = g_cnt[0].cnt_reg;
  assign flush_count  = g_cnt[1].cnt_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: stall/flush resolution, data-memory wait with timeout, halt.
// Optional performance counters are built only when PIPE_PERF_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hz_stall,
  input  logic             hz_flush,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             mem_wb_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             timeout_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              timeout_reg, timeout_next;
  logic              halted_reg;
  logic              advance;

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = timeout_reg;
    advance       = 1'b0;
    pc_we         = 1'b0;
    if_id_we      = 1'b0;
    id_ex_we      = 1'b0;
    ex_mem_we     = 1'b0;
    mem_wb_we     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;

    case (state_reg)
      ST_INIT: begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        mem_wb_flush = 1'b1;
        state_next   = ST_RUN;
      end
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_next    = ST_MEM_WAIT;
          wait_cnt_next = '0;
        end else begin
          advance = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          advance = 1'b1;
        end else begin
          // WB keeps receiving bubbles while the access is outstanding.
          mem_wb_flush  = 1'b1;
          wait_cnt_next = wait_cnt_reg + 1'b1;
          if (wait_cnt_reg == WAIT_W'(WAIT_MAX - 1)) begin
            timeout_next = 1'b1;
            state_next   = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase

    if (advance) begin
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      id_ex_we  = 1'b1;
      ex_mem_we = 1'b1;
      mem_wb_we = 1'b1;
      // Flush outranks stall; a stall outranks a missing fetch for IF/ID.
      if (hz_flush) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (hz_stall) begin
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_we       = 1'b0;
        if_id_flush = 1'b1;
      end
      state_next = halt_req ? ST_HALT : ST_RUN;
    end

    if (!reset_n) begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      mem_wb_we    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= ST_INIT;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
      halted_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
      halted_reg   <= (state_next == ST_HALT);
    end
  end

  assign state       = state_reg;
  assign halted      = halted_reg;
  assign timeout_err = timeout_reg;

`ifdef PIPE_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = reset_n && is_active(state_reg) && !pc_we;
  assign flush_inc = reset_n && advance && hz_flush;

  pipe_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall_inc   (stall_inc),
    .flush_inc   (flush_inc),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed and randomized bench for pipe_ctrl against a rule-level reference model.
module tb_pipe_ctrl;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 32;
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic clk = 1'b0;
  logic reset_n = 1'b0, hz_stall = 1'b0, hz_flush = 1'b0, imem_ready = 1'b1;
  logic dmem_req = 1'b0, dmem_ready = 1'b1, halt_req = 1'b0;
  logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic halted, timeout_err;
  logic [1:0] state;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  pipe_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .hz_stall(hz_stall), .hz_flush(hz_flush),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we),
    .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .halted(halted),
    .timeout_err(timeout_err), .state(state), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Reference model: phase 0=INIT 1=RUN 2=MEM_WAIT 3=HALT
  int m_phase = 0;
  int m_wait = 0;
  bit m_to = 1'b0;
  longint unsigned m_stall = 0, m_flush = 0;
  logic [4:0] e_we;   // {pc, if_id, id_ex, ex_mem, mem_wb}
  logic [3:0] e_fl;   // {if_id, id_ex, ex_mem, mem_wb}
  bit e_moving;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cycle);
    end
  endtask

  task automatic predict();
    e_we = 5'b00000;
    e_fl = 4'b0000;
    e_moving = ((m_phase == 1) && !(dmem_req && !dmem_ready)) || ((m_phase == 2) && dmem_ready);
    if (!reset_n || m_phase == 0) begin
      e_fl = 4'b1111;
      e_moving = 1'b0;
    end else if (m_phase == 2 && !dmem_ready) begin
      e_fl = 4'b0001;
    end else if (e_moving) begin
      e_we = 5'b11111;
      if (hz_flush) e_fl = 4'b1110;
      else if (hz_stall) begin e_we = 5'b00111; e_fl = 4'b0100; end
      else if (!imem_ready) begin e_we = 5'b01111; e_fl = 4'b1000; end
    end
  endtask

  task automatic advance_model();
    if (!reset_n) begin
      m_phase = 0; m_wait = 0; m_to = 1'b0; m_stall = 0; m_flush = 0;
      return;
    end
    if ((m_phase == 1 || m_phase == 2) && !e_we[4] && m_stall < CNT_MAX) m_stall++;
    if (e_moving && hz_flush && m_flush < CNT_MAX) m_flush++;
    case (m_phase)
      0: m_phase = 1;
      1: if (dmem_req && !dmem_ready) begin m_phase = 2; m_wait = 0; end
         else if (halt_req) m_phase = 3;
      2: if (dmem_ready) m_phase = halt_req ? 3 : 1;
         else begin
           m_wait++;
           if (m_wait >= WAIT_MAX) begin m_to = 1'b1; m_phase = 3; end
         end
      default: m_phase = m_phase;
    endcase
  endtask

  task automatic step(input bit rn, input bit hs, input bit hf, input bit im,
                      input bit dq, input bit dr, input bit hq);
    longint unsigned exp_stall, exp_flush;
    reset_n = rn; hz_stall = hs; hz_flush = hf; imem_ready = im;
    dmem_req = dq; dmem_ready = dr; halt_req = hq;
    #1;
    predict();
`ifdef PIPE_PERF_EN
    exp_stall = m_stall; exp_flush = m_flush;
`else
    exp_stall = 0; exp_flush = 0;
`endif
    check("write_enables", {59'd0, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we}, {59'd0, e_we});
    check("flushes", {60'd0, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}, {60'd0, e_fl});
    check("state", {62'd0, state}, 64'(m_phase));
    check("halted", {63'd0, halted}, {63'd0, (m_phase == 3)});
    check("timeout_err", {63'd0, timeout_err}, {63'd0, m_to});
    check("stall_cycles", 64'(stall_cycles), exp_stall);
    check("flush_count", 64'(flush_count), exp_flush);
    $display("cyc=%0d rn=%0b st=%0b fl=%0b im=%0b dq=%0b dr=%0b hq=%0b | state=%0d we=%05b flush=%04b halted=%0b to=%0b stalls=%0d flushes=%0d",
             cycle, rn, hs, hf, im, dq, dr, hq, state,
             {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we},
             {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush},
             halted, timeout_err, stall_cycles, flush_count);
    advance_model();
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 1, 0, 1, 0);
  endtask

  initial begin
    logic [CNT_W-1:0] s0;
    int halt_run;
    @(negedge clk);

    // Reset, one INIT cycle, then RUN
    step(0, 0, 0, 1, 0, 1, 0);
    step(0, 1, 1, 0, 1, 0, 1);
    step(1, 0, 0, 1, 0, 1, 0);
    check("init_exit_state", {62'd0, state}, 64'd1);
    idle(2);

    // Single-cycle stall, flush+stall, fetch bubble, fetch bubble with stall
    step(1, 1, 0, 1, 0, 1, 0);
    idle(1);
    step(1, 1, 1, 1, 0, 1, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    idle(1);

    // Memory wait: ready low for entry + 3 wait cycles, then completes
    s0 = stall_cycles;
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 1, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);
`ifdef PIPE_PERF_EN
    check("mem_wait_stall_delta", 64'(stall_cycles - s0), 64'd4);
`endif
    step(1, 0, 1, 1, 1, 1, 0);
    check("mem_wait_done_state", {62'd0, state}, 64'd1);
    idle(1);

    // Timeout: ready held low until the wait limit
    step(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < WAIT_MAX; i++) step(1, 0, 0, 1, 1, 0, 0);
    check("timeout_state", {62'd0, state}, 64'd3);
    check("timeout_flag", {63'd0, timeout_err}, 64'd1);
    step(1, 0, 0, 1, 1, 1, 0);
    step(1, 0, 1, 1, 0, 1, 0);

    // Reset during MEM_WAIT
    step(0, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0, 1, 0);
    idle(1);
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0, 0);
    check("reset_in_wait_state", {62'd0, state}, 64'd0);
    step(1, 0, 0, 1, 0, 1, 0);

    // halt_req in an advancing cycle, and on the completing MEM_WAIT cycle
    idle(1);
    step(1, 0, 1, 1, 0, 1, 1);
    step(1, 1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1, 1);
    check("halt_from_wait", {62'd0, state}, 64'd3);
    step(0, 0, 0, 1, 0, 1, 0);

    // Randomized traffic
    halt_run = 0;
    for (int i = 0; i < 600; i++) begin
      bit rn;
      halt_run = (m_phase == 3) ? halt_run + 1 : 0;
      rn = !(($urandom_range(99) < 2) || (halt_run >= 3));
      step(rn,
           $urandom_range(99) < 25,
           $urandom_range(99) < 15,
           $urandom_range(99) < 80,
           $urandom_range(99) < 30,
           $urandom_range(99) < 60,
           $urandom_range(99) < 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
